regfile_wb_arb: RTL and testbench

- Shares the register file's single write port among NUM_REQ writeback sources, for example the ALU, the load unit and CSR reads.
- Round-robin arbitration over valid/ready requesters.
- One registered output stage drives the register file's write enable, destination index and write value.
- Also exports a one-hot pending-write mask so hazard logic can see the write that is in flight.

---
 rtl/regfile_pkg.sv | 8 +
 rtl/regfile_wb_arb_rr_arbiter.sv | 29 ++
 rtl/regfile_wb_arb.sv | 69 ++++++
 tb/tb_regfile_wb_arb.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths and typedefs (REG_IDX_W, XLEN, NUM_REGS, reg_idx_t, xlen_t)
package regfile_pkg;
  localparam int REG_IDX_W = 5;
  localparam int XLEN = 32;
  localparam int NUM_REGS = 2 ** REG_IDX_W;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0] xlen_t;
endpackage

// File: rtl/regfile_wb_arb_rr_arbiter.sv
// rr_arbiter: round-robin grant from req starting at ptr; ports req/ptr in, gnt (one-hot), any, idx, nxt_ptr out
module rr_arbiter #(
  parameter int N = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any,
  output logic [PW-1:0] idx,
  output logic [PW-1:0] nxt_ptr
);
  int k;
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = '0;
    k = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!any && req[k]) begin
        any = 1'b1;
        gnt[k] = 1'b1;
        idx = PW'(k);
      end
    end
  end
  assign nxt_ptr = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
endmodule

// File: rtl/regfile_wb_arb.sv
// regfile_wb_arb: round-robin share of the register-file write port among NUM_REQ writeback sources.
// Ports: i_clk, i_rst_n (sync, active-low), i_req_valid/i_req_rd/i_req_val (flattened per requester),
// o_req_ready (grant), o_rd/o_rd_val/o_w_en (registered write port), o_pending_mask (one-hot in-flight rd).
// Macro REGFILE_WB_ARB_X0_DROP_EN: acknowledge rd=0 requests immediately without using the write slot.
module regfile_wb_arb
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN = regfile_pkg::XLEN,
  parameter int REG_IDX_W = regfile_pkg::REG_IDX_W
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*REG_IDX_W-1:0]  i_req_rd,
  input  logic [NUM_REQ*XLEN-1:0]       i_req_val,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [REG_IDX_W-1:0]          o_rd,
  output logic [XLEN-1:0]               o_rd_val,
  output logic                          o_w_en,
  output logic [2**REG_IDX_W-1:0]       o_pending_mask
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int NREGS = 2 ** REG_IDX_W;
  logic [PW-1:0] rr_ptr, idx, nxt_ptr;
  logic [NUM_REQ-1:0] arb_req, gnt;
  logic any;
  logic [REG_IDX_W-1:0] sel_rd;
  logic [XLEN-1:0] sel_val;
`ifdef REGFILE_WB_ARB_X0_DROP_EN
  logic [NUM_REQ-1:0] x0;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_x0
    assign x0[g] = i_req_valid[g] && i_req_rd[g*REG_IDX_W +: REG_IDX_W] == '0;
  end
  // x0 writes are acknowledged and discarded, so they never compete for the slot
  assign arb_req = i_rst_n ? i_req_valid & ~x0 : '0;
  assign o_req_ready = i_rst_n ? gnt | x0 : '0;
`else
  assign arb_req = i_rst_n ? i_req_valid : '0;
  assign o_req_ready = gnt;
`endif
  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req(arb_req),
    .ptr(rr_ptr),
    .gnt(gnt),
    .any(any),
    .idx(idx),
    .nxt_ptr(nxt_ptr)
  );
  assign sel_rd = i_req_rd[idx*REG_IDX_W +: REG_IDX_W];
  assign sel_val = i_req_val[idx*XLEN +: XLEN];
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rr_ptr <= '0;
      o_w_en <= 1'b0;
      o_rd <= '0;
      o_rd_val <= '0;
      o_pending_mask <= '0;
    end else begin
      o_w_en <= any;
      o_pending_mask <= any ? NREGS'(1) << sel_rd : '0;
      if (any) begin
        rr_ptr <= nxt_ptr;
        o_rd <= sel_rd;
        o_rd_val <= sel_val;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arb.sv
// tb_regfile_wb_arb: directed scoreboard bench for regfile_wb_arb with NUM_REQ=3
module tb_regfile_wb_arb;
  localparam int N = 3;
  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] v;
  logic [4:0] rd [N];
  logic [31:0] val [N];
  logic [N-1:0] ready;
  logic [4:0] o_rd;
  logic [31:0] o_rd_val;
  logic o_w_en;
  logic [31:0] o_mask;
  typedef struct packed {
    logic w;
    logic [4:0] rd;
    logic [31:0] val;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_mis = 0;
  int m_ptr = 0;
  logic [4:0] m_rd = '0;
  logic [31:0] m_val = '0;
  always #5 clk = ~clk;
  regfile_wb_arb #(.NUM_REQ(N), .XLEN(32), .REG_IDX_W(5)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_req_valid(v),
    .i_req_rd({rd[2], rd[1], rd[0]}),
    .i_req_val({val[2], val[1], val[0]}),
    .o_req_ready(ready),
    .o_rd(o_rd),
    .o_rd_val(o_rd_val),
    .o_w_en(o_w_en),
    .o_pending_mask(o_mask)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cycle();
    logic [N-1:0] x0, areq, g, er;
    int gi, k;
    exp_t e;
    @(negedge clk);
    x0 = '0;
`ifdef REGFILE_WB_ARB_X0_DROP_EN
    for (int j = 0; j < N; j++) x0[j] = rst_n && v[j] && rd[j] == 5'd0;
`endif
    areq = rst_n ? v & ~x0 : '0;
    g = '0;
    gi = -1;
    for (int i = 0; i < N; i++) begin
      k = (m_ptr + i) % N;
      if (gi < 0 && areq[k]) gi = k;
    end
    if (gi >= 0) g[gi] = 1'b1;
    er = g | x0;
    chk("ready", 64'(ready), 64'(er));
    if (!rst_n) begin
      m_ptr = 0;
      m_rd = '0;
      m_val = '0;
    end else if (gi >= 0) begin
      m_rd = rd[gi];
      m_val = val[gi];
      m_ptr = (gi + 1) % N;
    end
    e.w = rst_n && gi >= 0;
    e.rd = m_rd;
    e.val = m_val;
    q.push_back(e);
    @(posedge clk);
    #1;
    v = v & ~er;
    if (q.size() == 0) begin
      chk("queue_empty", 64'(1), 64'(0));
    end else begin
      e = q.pop_front();
      chk("w_en", 64'(o_w_en), 64'(e.w));
      chk("rd", 64'(o_rd), 64'(e.rd));
      chk("rd_val", 64'(o_rd_val), 64'(e.val));
      chk("pending_mask", 64'(o_mask), e.w ? 64'(32'd1 << e.rd) : 64'd0);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    v = 3'b001;
    rd[0] = 5'd5; rd[1] = 5'd9; rd[2] = 5'd12;
    val[0] = 32'hDEADBEEF; val[1] = 32'h1111; val[2] = 32'h2222;
    cycle();
    cycle();
    v = 3'b001;
    rst_n = 1'b1;
    cycle();
    cycle();
    chk("single_rd5", 64'(o_mask), 64'h0);
    v = 3'b100;
    cycle();
    rd[0] = 5'd1; rd[1] = 5'd2; val[0] = 32'hA0; val[1] = 32'hB1;
    for (int i = 0; i < 4; i++) begin
      v = 3'b011;
      cycle();
    end
    v = 3'b000;
    cycle();
    v = 3'b010;
    cycle();
    v = 3'b101;
    cycle();
    cycle();
    v = 3'b111;
    cycle();
    v = 3'b000;
    cycle();
    v = 3'b100;
    cycle();
    rd[0] = 5'd7; rd[1] = 5'd7; val[0] = 32'd1; val[1] = 32'd2;
    v = 3'b011;
    cycle();
    cycle();
    cycle();
    v = 3'b001;
    cycle();
    rst_n = 1'b0;
    v = 3'b001;
    cycle();
    rst_n = 1'b1;
    v = 3'b011;
    cycle();
    v = 3'b000;
    cycle();
    rd[0] = 5'd0; rd[1] = 5'd3; val[0] = 32'hC0; val[1] = 32'hC3;
    v = 3'b011;
    cycle();
    cycle();
    cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
